dma_fifo_pf: RTL and testbench
==============================

Name: dma_fifo_pf

Overview:
Parametrised successor to the DMA channel FIFO. It is a single-clock, first-word-fall-through buffer between the DMA read engine and the AXI write engine. The block adds:
- depth that follows AWIDTH exactly;
- correct simultaneous push/pull at the full and empty boundaries;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- synchronous flush;
- a high-water-mark level monitor.

Parameters:
DWIDTH, 32, data word width in bits
AWIDTH, 5, address width; DEPTH = 2**AWIDTH entries (legal range 1..10)
DEPTH, 2**AWIDTH, derived entry count; must not be overridden

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous active-low reset
push  input  1  write request; data_in is captured when the write is accepted
pull  input  1  read request; pops the head entry when the read is accepted
data_in  input  DWIDTH  write data
data_out  output  DWIDTH  head-of-queue data (FWFT)
flush  input  1  synchronous clear of queue contents
err_clr  input  1  clears overflow, underflow and max_level
af_thresh  input  AWIDTH+1  almost-full threshold (level)
ae_thresh  input  AWIDTH+1  almost-empty threshold (level)
count  output  AWIDTH+1  entries currently stored, 0..DEPTH
depth_left  output  AWIDTH+1  free entries, always DEPTH-count
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
max_level  output  AWIDTH+1  highest count reached since reset or err_clr

Behaviour:
- Reset (rst low, asynchronous):
  - w_ptr = r_ptr = 0, count = 0, depth_left = DEPTH.
  - overflow = underflow = 0, max_level = 0.
  - data_out = 0, full = 0, empty = 1.
  - Storage array is not reset.
- Pointers are AWIDTH bits and wrap from DEPTH-1 to 0 without special handling. count is a separate AWIDTH+1-bit register.
- Accept rules (evaluated on the current-cycle count):
  - wr_ok = push && (!full || pull).
  - rd_ok = pull && !empty.
  - At full with push && pull: both are accepted and count is unchanged.
  - At empty with push && pull: only the push is accepted, count goes to 1, and the pull is rejected (underflow set).
- On an accepted write: mem[w_ptr] <= data_in, w_ptr++.
- On an accepted read: r_ptr++.
- count update: count += wr_ok - rd_ok.
- data_out:
  - Driven combinationally as mem[r_ptr] when !empty, else 0.
  - Read latency is 0: the first written word appears on data_out in the cycle after the push edge.
- Flags: full, empty, almost_full and almost_empty are combinational from the count register and the thresholds.
  - af_thresh = 0 forces almost_full = 1.
  - ae_thresh >= DEPTH forces almost_empty = 1.
- overflow is set on push && full && !pull.
- underflow is set on pull && empty, independent of push.
- err_clr:
  - Clears overflow, underflow and max_level.
  - A set event in the same cycle wins, so the flag remains 1.
  - max_level reloads to next-cycle count.
- max_level <= max(max_level, next count) every cycle.
- flush:
  - Pointers and count go to 0 at the next edge; data_out becomes 0.
  - push and pull are ignored in that cycle, and no overflow or underflow is flagged.
  - Sticky flags and max_level are unaffected.
  - flush has priority over err_clr only for the queue state; err_clr still acts in the same cycle.
- Reset asserted mid-transfer aborts all operations immediately. Contents are lost logically even though the array is not cleared.
- Assertions, disabled during reset:
  - count <= DEPTH.
  - depth_left + count == DEPTH.
  - !(full && empty).

Test Plan:
- AWIDTH=3 (DEPTH 8): reset, then push 8 words 0xA0..0xA7 → count=8, full=1, depth_left=0, max_level=8, data_out=0xA0; a further push → overflow=1, count stays 8.
- Full FIFO, push=pull=1 with data_in=0xB0 → data_out advances to 0xA1, count stays 8, overflow stays 0; after 7 more pulls the last word read is 0xB0.
- Empty FIFO, push=pull=1 with data_in=0x55 → count=1, data_out=0x55 next cycle, underflow=1; err_clr → underflow=0, max_level=1.
- af_thresh=6, ae_thresh=2: push 1 word per cycle from empty → almost_empty drops when count reaches 3, almost_full rises when count reaches 6.
- Wrap-around: 20 push/pull cycles interleaved with the level held at 3 → data_out sequence is in order with no loss across pointer wrap 7→0.
- count=5, assert flush together with push → count=0, empty=1, data_out=0, overflow and underflow unchanged, max_level stays 5. Separately, drop rst mid-push burst → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dma_fifo_pf.sv
// Single-clock FWFT channel FIFO between the DMA read and AXI write engines.
// Adds level flags, sticky error flags, flush and a high-water-mark monitor.
module dma_fifo_pf #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pull,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  input  logic              flush,
  input  logic              err_clr,
  input  logic [AWIDTH:0]   af_thresh,
  input  logic [AWIDTH:0]   ae_thresh,
  output logic [AWIDTH:0]   count,
  output logic [AWIDTH:0]   depth_left,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [AWIDTH:0]   max_level
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DCNT = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] w_ptr;
  logic [AWIDTH-1:0] r_ptr;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_set;
  logic              udf_set;
  logic [AWIDTH:0]   cnt_nxt;
  logic [AWIDTH:0]   ml_nxt;

  assign full         = (count == DCNT);
  assign empty        = (count == '0);
  assign depth_left   = DCNT - count;
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign data_out     = empty ? '0 : mem[r_ptr];

  // Flush swallows the cycle's push/pull, so neither error can fire.
  always_comb begin
    wr_ok   = push && (!full || pull) && !flush;
    rd_ok   = pull && !empty && !flush;
    ovf_set = push && full && !pull && !flush;
    udf_set = pull && empty && !flush;
    cnt_nxt = count;
    unique case (1'b1)
      flush:            cnt_nxt = '0;
      wr_ok && !rd_ok:  cnt_nxt = count + 1'b1;
      rd_ok && !wr_ok:  cnt_nxt = count - 1'b1;
      default:          cnt_nxt = count;
    endcase
    ml_nxt = max_level;
    if (err_clr)
      ml_nxt = cnt_nxt;
    else if (cnt_nxt > max_level)
      ml_nxt = cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[w_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      max_level <= '0;
    end else begin
      if (flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (wr_ok) w_ptr <= w_ptr + 1'b1;
        if (rd_ok) r_ptr <= r_ptr + 1'b1;
      end
      count     <= cnt_nxt;
      overflow  <= ovf_set | (overflow & !err_clr);
      underflow <= udf_set | (underflow & !err_clr);
      max_level <= ml_nxt;
    end
  end

  a_cnt_range: assert property (
    @(posedge clk) disable iff (!rst) count <= DCNT);
  a_cnt_sum: assert property (
    @(posedge clk) disable iff (!rst) depth_left + count == DCNT);
  a_full_empty: assert property (
    @(posedge clk) disable iff (!rst) !(full && empty));

endmodule

// File: tb/tb_dma_fifo_pf.sv
// Bench for dma_fifo_pf (DEPTH 8): directed plan steps then random traffic,
// all checked against a queue-based reference model.
module tb_dma_fifo_pf;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pull, flush, err_clr;
  logic [DW-1:0] data_in, data_out;
  logic [AW:0]   af_thresh, ae_thresh;
  logic [AW:0]   count, depth_left, max_level;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow, underflow;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned q[$];
  bit          m_ovf, m_udf;
  int          m_max;

  dma_fifo_pf #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pull(pull),
    .data_in(data_in), .data_out(data_out),
    .flush(flush), .err_clr(err_clr),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count), .depth_left(depth_left),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow),
    .max_level(max_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned lvl;
    lvl = q.size();
    chk("count", 32'(count), lvl);
    chk("depth_left", 32'(depth_left), D - lvl);
    chk("full", 32'(full), 32'(lvl == D));
    chk("empty", 32'(empty), 32'(lvl == 0));
    chk("data_out", data_out, (lvl != 0) ? q[0] : 0);
    chk("almost_full", 32'(almost_full), 32'(lvl >= af_thresh));
    chk("almost_empty", 32'(almost_empty), 32'(lvl <= ae_thresh));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("max_level", 32'(max_level), m_max);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_max = 0;
  endtask

  // One clock: drive at negedge, advance model, check 1 time unit after edge.
  task automatic cycle(input bit p, input bit r, input int unsigned d,
                       input bit fl, input bit ec);
    int   lvl;
    bit   ovf_ev, udf_ev;
    @(negedge clk);
    push = p; pull = r; data_in = d; flush = fl; err_clr = ec;
    lvl = q.size();
    ovf_ev = 0;
    udf_ev = 0;
    if (fl) begin
      q.delete();
    end else begin
      if (p && lvl == D && !r) ovf_ev = 1;
      if (r && lvl == 0) udf_ev = 1;
      if (r && lvl > 0) void'(q.pop_front());
      if (p && (lvl < D || r)) q.push_back(d);
    end
    if (ec) begin
      m_ovf = ovf_ev;
      m_udf = udf_ev;
      m_max = q.size();
    end else begin
      m_ovf = m_ovf | ovf_ev;
      m_udf = m_udf | udf_ev;
      if (q.size() > m_max) m_max = q.size();
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    push = 0; pull = 0; flush = 0; err_clr = 0;
    data_in = '0;
    af_thresh = 4'd6;
    ae_thresh = 4'd2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_depth_left", 32'(depth_left), 8);
    @(negedge clk);
    rst = 1'b1;

    // Fill to full, then one rejected push.
    for (int i = 0; i < 8; i++) cycle(1, 0, 32'hA0 + i, 0, 0);
    chk("fill_head", data_out, 32'hA0);
    chk("fill_full", 32'(full), 1);
    chk("fill_max", 32'(max_level), 8);
    cycle(1, 0, 32'hEE, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    cycle(0, 0, 0, 0, 1);

    // Simultaneous push/pull at full.
    cycle(1, 1, 32'hB0, 0, 0);
    chk("full_pp_head", data_out, 32'hA1);
    chk("full_pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, 0);
    chk("last_word", data_out, 32'hB0);
    cycle(0, 1, 0, 0, 0);

    // Simultaneous push/pull at empty.
    cycle(1, 1, 32'h55, 0, 0);
    chk("empty_pp_data", data_out, 32'h55);
    chk("empty_pp_udf", 32'(underflow), 1);
    cycle(0, 0, 0, 0, 1);
    chk("errclr_udf", 32'(underflow), 0);
    chk("errclr_max", 32'(max_level), 1);
    cycle(0, 1, 0, 0, 0);

    // Threshold ramp.
    for (int i = 0; i < 6; i++) cycle(1, 0, 32'hC0 + i, 0, 0);
    chk("ramp_af", 32'(almost_full), 1);

    // Hold level 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 32'hD00 + i, 0, 0);
    chk("wrap_head", data_out, 32'hD11);

    // Flush at level 5 with a push.
    cycle(1, 0, 32'hE0, 0, 0);
    cycle(1, 0, 32'hE1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("pre_flush_max", 32'(max_level), 5);
    cycle(1, 0, 32'hE2, 1, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_data", data_out, 0);
    chk("flush_max", 32'(max_level), 5);

    // Asynchronous reset in the middle of a push burst.
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'hF0 + i, 0, 0);
    @(negedge clk);
    push = 1; data_in = 32'hF9;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    push = 0;
    rst = 1'b1;

    // Random traffic with random thresholds.
    for (int i = 0; i < 400; i++) begin
      af_thresh = 4'($urandom_range(0, 9));
      ae_thresh = 4'($urandom_range(0, 9));
      cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
            $urandom, 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 14) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
